// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, access kinds and
// the width of the wait-state counter.
package mem_port_arbiter_pkg;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        AK_FETCH = 2'd0,
        AK_LOAD  = 2'd1,
        AK_DRAIN = 2'd2,
        AK_STORE = 2'd3
    } kind_e;

    function automatic logic kind_is_read(input kind_e k);
        return (k == AK_FETCH) || (k == AK_LOAD);
    endfunction

endpackage

// File: rtl/mem_wbuf_fifo.sv
// Circular store buffer: head fields for draining plus a combinational
// "any valid entry holds this word address" match for load hazards.
module mem_wbuf_fifo #(
    parameter int AW    = 30,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [31:0]   i_push_wdata,
    input  logic [3:0]    i_push_bwe,
    input  logic          i_pop,
    input  logic [AW-1:0] i_match_addr,
    output logic [AW-1:0] o_head_addr,
    output logic [31:0]   o_head_wdata,
    output logic [3:0]    o_head_bwe,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_match
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]             r_wr_ptr, r_rd_ptr;
    logic [PW:0]               r_count;
    logic [DEPTH-1:0][AW-1:0]  r_addr;
    logic [DEPTH-1:0][31:0]    r_wdata;
    logic [DEPTH-1:0][3:0]     r_bwe;
    logic [DEPTH-1:0]          w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_bwe    <= '0;
        end else begin
            if (i_push) begin
                r_addr[r_wr_ptr]  <= i_push_addr;
                r_wdata[r_wr_ptr] <= i_push_wdata;
                r_bwe[r_wr_ptr]   <= i_push_bwe;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] w_off;
        assign w_off    = PW'(g) - r_rd_ptr;
        assign w_hit[g] = ({1'b0, w_off} < r_count) && (r_addr[g] == i_match_addr);
    end

    assign o_match      = |w_hit;
    assign o_head_addr  = r_addr[r_rd_ptr];
    assign o_head_wdata = r_wdata[r_rd_ptr];
    assign o_head_bwe   = r_bwe[r_rd_ptr];
    assign o_full       = (r_count == (PW+1)'(DEPTH));
    assign o_empty      = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between fetch and load/store. Define MEM_ARB_WBUF_EN
// to post stores into a write buffer drained when the port is otherwise idle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int SRAM_WAIT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_ready,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_bwe,
    output logic [31:0]       data_rdata,
    output logic              data_ready,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bwe,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    input  logic [31:0]       sram_rdata,
    output logic              wbuf_empty
);
    localparam int                AW       = ADDR_W - 2;
    localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(SRAM_WAIT);

    state_e            r_state, w_state_nxt;
    kind_e             r_kind, w_kind_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [AW-1:0]     r_addr, w_st_addr;
    logic [31:0]       r_wdata, w_st_wdata;
    logic [3:0]        r_bwe, w_st_bwe;
    logic [31:0]       r_inst_rdata, r_data_rdata;
    logic              w_start, w_push, w_pop, w_last;
    logic [AW-1:0]     w_head_addr;
    logic [31:0]       w_head_wdata;
    logic [3:0]        w_head_bwe;
    logic              w_unused;

    assign w_last = (r_cnt == LAST_CNT);

`ifdef MEM_ARB_WBUF_EN
    logic w_full, w_empty, w_match;

    mem_wbuf_fifo #(.AW(AW), .DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (data_addr[ADDR_W-1:2]),
        .i_push_wdata(data_wdata),
        .i_push_bwe  (data_bwe),
        .i_pop       (w_pop),
        .i_match_addr(data_addr[ADDR_W-1:2]),
        .o_head_addr (w_head_addr),
        .o_head_wdata(w_head_wdata),
        .o_head_bwe  (w_head_bwe),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_match     (w_match)
    );
    assign wbuf_empty = w_empty;
    assign w_unused   = ^{inst_addr[1:0], data_addr[1:0]};
`else
    assign w_head_addr  = '0;
    assign w_head_wdata = '0;
    assign w_head_bwe   = '0;
    assign wbuf_empty   = 1'b1;
    assign w_unused     = ^{inst_addr[1:0], data_addr[1:0], w_push, w_pop};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef MEM_ARB_WBUF_EN
                // A load that hits a buffered word drains one entry per pass until clear.
                if (data_read) begin
                    w_start    = 1'b1;
                    w_kind_nxt = w_match ? AK_DRAIN : AK_LOAD;
                end else if (data_write) begin
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_kind_nxt  = AK_STORE;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_start    = 1'b1;
                        w_kind_nxt = AK_DRAIN;
                    end
                end else if (w_full) begin
                    w_start    = 1'b1;
                    w_kind_nxt = AK_DRAIN;
                end else if (inst_req) begin
                    w_start    = 1'b1;
                    w_kind_nxt = AK_FETCH;
                end else if (!w_empty) begin
                    w_start    = 1'b1;
                    w_kind_nxt = AK_DRAIN;
                end
`else
                if (data_read) begin
                    w_start    = 1'b1;
                    w_kind_nxt = AK_LOAD;
                end else if (data_write) begin
                    w_start    = 1'b1;
                    w_kind_nxt = AK_STORE;
                end else if (inst_req) begin
                    w_start    = 1'b1;
                    w_kind_nxt = AK_FETCH;
                end
`endif
                if (w_start)
                    w_state_nxt = ST_ACC;
            end
            ST_ACC: begin
                if (w_last) begin
                    w_pop       = (r_kind == AK_DRAIN);
                    w_state_nxt = (r_kind == AK_DRAIN) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_st_addr  = data_addr[ADDR_W-1:2];
        w_st_wdata = data_wdata;
        w_st_bwe   = data_bwe;
        case (w_kind_nxt)
            AK_FETCH: begin
                w_st_addr  = inst_addr[ADDR_W-1:2];
                w_st_wdata = '0;
                w_st_bwe   = '0;
            end
            AK_DRAIN: begin
                w_st_addr  = w_head_addr;
                w_st_wdata = w_head_wdata;
                w_st_bwe   = w_head_bwe;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_kind  <= AK_FETCH;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
        end
    end

    // Address/data latch once on entry to ACC so they stay stable for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_bwe        <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_start) begin
                r_cnt   <= '0;
                r_addr  <= w_st_addr;
                r_wdata <= w_st_wdata;
                r_bwe   <= w_st_bwe;
            end else if (r_state == ST_ACC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_ACC && w_last && r_kind == AK_FETCH)
                r_inst_rdata <= sram_rdata;
            if (r_state == ST_ACC && w_last && r_kind == AK_LOAD)
                r_data_rdata <= sram_rdata;
        end
    end

    assign sram_ce    = (r_state == ST_ACC);
    assign sram_oe    = sram_ce && kind_is_read(r_kind);
    assign sram_we    = sram_ce && !kind_is_read(r_kind);
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_bwe   = r_bwe;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;
    assign inst_ready = (r_state == ST_DONE) && (r_kind == AK_FETCH);
    assign data_ready = (r_state == ST_DONE) && (r_kind != AK_FETCH);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expectations adapt to MEM_ARB_WBUF_EN.
module tb_mem_port_arbiter;
    localparam int W = 1;
`ifdef MEM_ARB_WBUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_read, data_write;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_bwe;
    logic [31:0] inst_rdata, data_rdata, sram_wdata, sram_rdata;
    logic        inst_ready, data_ready, sram_ce, sram_oe, sram_we, wbuf_empty;
    logic [29:0] sram_addr;
    logic [3:0]  sram_bwe;

    typedef struct {
        string       tag;
        bit          inst;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [29:0] wlog[$];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        prev_we;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .WBUF_DEPTH(4), .SRAM_WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_bwe(data_bwe), .data_rdata(data_rdata), .data_ready(data_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_bwe(sram_bwe),
        .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we), .sram_rdata(sram_rdata),
        .wbuf_empty(wbuf_empty)
    );

    // SRAM model: asynchronous read, byte-masked write on the clock edge.
    assign sram_rdata = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        prev_we <= sram_we;
        if (sram_we && !prev_we) wlog.push_back(sram_addr);
        if (sram_ce && sram_we)
            for (int b = 0; b < 4; b++)
                if (sram_bwe[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 ^ (i * 32'h0001_0003);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        inst_req   = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic push_exp(input string tag, input bit inst, input logic [31:0] d, input int lat);
        exp_t e;
        e.tag = tag; e.inst = inst; e.data = d; e.lat = lat;
        sb.push_back(e);
    endtask

    // Waits for a ready pulse, then pops and checks the oldest expectation.
    task automatic wait_ready(output int oe_cnt, output logic [29:0] oe_addr);
        int   lat;
        bit   done;
        exp_t e;
        lat = 0; oe_cnt = 0; oe_addr = '0; done = 1'b0;
        while (!done) begin
            next_cycle();
            lat++;
            if (sram_oe) begin
                oe_cnt++;
                oe_addr = sram_addr;
            end
            if (inst_ready || data_ready) done = 1'b1;
            else if (lat >= 60) begin
                chk("ready_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "/port"}, 32'(inst_ready), 32'(e.inst));
            chk({e.tag, "/lat"}, 32'(lat), 32'(e.lat));
            if (e.tag.substr(0, 1) != "st")
                chk({e.tag, "/data"}, e.inst ? inst_rdata : data_rdata, e.data);
        end
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] bwe, input int lat);
        int          oc;
        logic [29:0] oa;
        data_addr = a; data_wdata = d; data_bwe = bwe; data_write = 1'b1;
        for (int b = 0; b < 4; b++)
            if (bwe[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        push_exp(tag, 1'b0, 32'h0, lat);
        wait_ready(oc, oa);
        drop_reqs();
        next_cycle();
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input int lat);
        int          oc;
        logic [29:0] oa;
        data_addr = a; data_read = 1'b1;
        push_exp(tag, 1'b0, ref_mem[a[9:2]], lat);
        wait_ready(oc, oa);
        drop_reqs();
        next_cycle();
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!wbuf_empty && n < 100) begin
            next_cycle();
            n++;
        end
        while (sram_ce && n < 100) begin
            next_cycle();
            n++;
        end
        chk({tag, "/drained"}, 32'(wbuf_empty), 32'd1);
    endtask

    initial begin
        int          oc, base, nrdy;
        logic [29:0] oa;
        bit          seen;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        drop_reqs();
        inst_addr = '0; data_addr = '0; data_wdata = '0; data_bwe = '0;
        rst = 1'b1;
        #2;
        chk("rst_inst_ready", 32'(inst_ready), 32'd0);
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        chk("rst_strobes", 32'({sram_ce, sram_oe, sram_we, sram_bwe}), 32'd0);
        chk("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();

        // Fetch of 0x100: word 0x40, oe held for SRAM_WAIT+1 cycles.
        inst_addr = 32'h100; inst_req = 1'b1;
        push_exp("fetch", 1'b1, ref_mem[8'h40], W + 2);
        wait_ready(oc, oa);
        chk("fetch/oe_cycles", 32'(oc), 32'(W + 1));
        chk("fetch/sram_addr", 32'(oa), 32'h40);
        drop_reqs();
        next_cycle();
        chk("fetch/pulse_w", 32'(inst_ready), 32'd0);

        // Two stores drain in issue order with no other traffic.
        base = wlog.size();
        do_store("st10", 32'h10, 32'h1122_3344, 4'b0101, BUF ? 1 : W + 2);
        do_store("st14", 32'h14, 32'hCAFE_F00D, 4'b1111, BUF ? 1 : W + 2);
        wait_empty("st2");
        chk("st2/nwrites", 32'(wlog.size() - base), 32'd2);
        if (wlog.size() - base == 2) begin
            chk("st2/first", 32'(wlog[base]), 32'h4);
            chk("st2/second", 32'(wlog[base + 1]), 32'h5);
        end
        do_load("ld10", 32'h10, W + 2);

        // Store then load to the same word: buffered write drains first.
        do_store("st20", 32'h20, 32'hDEAD_BEEF, 4'b1111, BUF ? 1 : W + 2);
        do_load("ld20", 32'h20, BUF ? 2 * W + 4 : W + 2);
        chk("ld20/value", data_rdata, 32'hDEAD_BEEF);
        wait_empty("ld20");

        // Five back-to-back stores against a four-entry buffer.
        base = wlog.size();
        for (int i = 0; i < 5; i++)
            do_store($sformatf("st5_%0d", i), 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i),
                     4'b1111, BUF ? ((i == 4) ? W + 3 : 1) : W + 2);
        wait_empty("st5");
        chk("st5/nwrites", 32'(wlog.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (base + i < wlog.size())
                chk($sformatf("st5/order%0d", i), 32'(wlog[base + i]), 32'h10 + 32'(i));
        do_load("ld4c", 32'h4C, W + 2);

        // Load and fetch together: load wins, then fetch, single-cycle pulses.
        data_addr = 32'h30; data_read = 1'b1;
        inst_addr = 32'h34; inst_req = 1'b1;
        push_exp("pri_ld", 1'b0, ref_mem[8'h0C], W + 2);
        push_exp("pri_if", 1'b1, ref_mem[8'h0D], W + 2);
        wait_ready(oc, oa);
        data_read = 1'b0;
        next_cycle();
        chk("pri_ld/pulse_w", 32'(data_ready), 32'd0);
        chk("pri_ld/no_inst", 32'(inst_ready), 32'd0);
        wait_ready(oc, oa);
        drop_reqs();
        next_cycle();
        chk("pri_if/pulse_w", 32'(inst_ready), 32'd0);

        // Reset in the middle of a write access.
        data_addr = 32'h60; data_wdata = 32'h5555_AAAA; data_bwe = 4'hF; data_write = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            next_cycle();
            if (data_ready) drop_reqs();
            if (sram_we) seen = 1'b1;
        end
        chk("rstacc/we_seen", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstacc/we", 32'(sram_we), 32'd0);
        chk("rstacc/ce", 32'(sram_ce), 32'd0);
        chk("rstacc/wbuf_empty", 32'(wbuf_empty), 32'd1);
        drop_reqs();
        next_cycle();
        rst = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (inst_ready || data_ready) nrdy++;
        end
        chk("rstacc/no_ready", 32'(nrdy), 32'd0);
        do_load("ld14", 32'h14, W + 2);
        chk("sb/leftover", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
